// File: rtl/node_exec_if.sv
// Port-side handshake bundle of one grid node: four inbound words with
// valid/ready, and one shared outbound word with per-port valid/ready.
interface node_exec_if;
  logic [43:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [10:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;

  // Neighbours/environment drive inbound data and accept outbound data.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/node_exec.sv
// node_exec: execution core of one grid node (ACC/BAK, port reads/writes, jumps).
// Define TIS_SAT_EN to clamp ADD/SUB/NEG results and IMM operands to [-999, 999].
module node_exec (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [20:0]        opcode,
  node_exec_if.slave         ports,
  output logic [3:0]         op,
  output logic signed [10:0] acc,
  output logic signed [10:0] jmp_off,
  output logic               clk_en
);

  localparam logic [3:0] OP_NOP = 4'd0,  OP_MOV = 4'd1,  OP_SWP = 4'd2,
                         OP_SAV = 4'd3,  OP_ADD = 4'd4,  OP_SUB = 4'd5,
                         OP_NEG = 4'd6,  OP_JRO = 4'd12;

  localparam logic [2:0] SRC_IMM = 3'd0, SRC_ACC = 3'd1,
                         SRC_UP  = 3'd3, SRC_DOWN = 3'd4,
                         SRC_LEFT = 3'd5, SRC_RIGHT = 3'd6;
  localparam logic [2:0] DST_ACC = 3'd1;

  typedef enum logic {S_RUN, S_WR} state_t;

  function automatic logic signed [10:0] fit(input logic signed [11:0] v);
`ifdef TIS_SAT_EN
    if (v > 12'sd999)       return 11'sd999;
    else if (v < -12'sd999) return -11'sd999;
    else                    return v[10:0];
`else
    return v[10:0];
`endif
  endfunction

  // Port codes 3..6 map to in_data/in_valid lane 0..3 (UP, DOWN, LEFT, RIGHT).
  function automatic logic [1:0] port_idx(input logic [2:0] code);
    case (code)
      SRC_DOWN:  return 2'd1;
      SRC_LEFT:  return 2'd2;
      SRC_RIGHT: return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic signed [10:0]  acc_q, acc_d, bak_q, bak_d;
  logic [10:0]         out_data_q;
  logic [1:0]          out_port_q;
  logic                load_out, clk_en_c;
  logic [3:0]          in_ready_c, out_valid_c;

  logic [3:0]          op_c;
  logic [2:0]          src, dst;
  logic signed [10:0]  imm, imm_eff, src_val;
  logic signed [11:0]  acc_x, src_x;
  logic [1:0]          src_idx, dst_idx;
  logic                src_is_port, dst_is_port, uses_src, src_ok;

  assign op_c        = opcode[20:17];
  assign src         = opcode[16:14];
  assign dst         = opcode[13:11];
  assign imm         = opcode[10:0];
  assign imm_eff     = fit({imm[10], imm});
  assign src_idx     = port_idx(src);
  assign dst_idx     = port_idx(dst);
  assign src_is_port = (src >= SRC_UP) && (src <= SRC_RIGHT);
  assign dst_is_port = (dst >= SRC_UP) && (dst <= SRC_RIGHT);
  assign uses_src    = op_c inside {OP_MOV, OP_ADD, OP_SUB, OP_JRO};
  assign src_ok      = !(uses_src && src_is_port) || ports.in_valid[src_idx];

  always_comb begin
    case (src)
      SRC_IMM:                          src_val = imm_eff;
      SRC_ACC:                          src_val = acc_q;
      SRC_UP, SRC_DOWN, SRC_LEFT,
      SRC_RIGHT:                        src_val = ports.in_data[11*src_idx +: 11];
      default:                          src_val = 11'sd0;
    endcase
  end

  // Sign-extended 12-bit operands keep the true sum visible before wrap/clamp.
  assign acc_x = {acc_q[10], acc_q};
  assign src_x = {src_val[10], src_val};

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no branch can infer a latch.
    state_d     = state_q;
    clk_en_c    = 1'b0;
    in_ready_c  = '0;
    out_valid_c = '0;
    acc_d       = acc_q;
    bak_d       = bak_q;
    load_out    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (uses_src && src_is_port) in_ready_c[src_idx] = 1'b1;
        if (src_ok) begin
          if (op_c == OP_MOV && dst_is_port) begin
            load_out = 1'b1;
            state_d  = S_WR;
          end else begin
            clk_en_c = 1'b1;
            case (op_c)
              OP_MOV: if (dst == DST_ACC) acc_d = src_val;
              OP_SWP: begin
                acc_d = bak_q;
                bak_d = acc_q;
              end
              OP_SAV: bak_d = acc_q;
              OP_ADD: acc_d = fit(acc_x + src_x);
              OP_SUB: acc_d = fit(acc_x - src_x);
              OP_NEG: acc_d = fit(12'sd0 - acc_x);
              default: ;  // NOP, jumps and codes 13-15 only advance the PC
            endcase
          end
        end
      end
      S_WR: begin
        out_valid_c[out_port_q] = 1'b1;
        if (ports.out_ready[out_port_q]) begin
          clk_en_c = 1'b1;
          state_d  = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_RUN;
      acc_q      <= '0;
      bak_q      <= '0;
      out_data_q <= '0;
      out_port_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      bak_q   <= bak_d;
      if (load_out) begin
        out_data_q <= src_val;
        out_port_q <= dst_idx;
      end
    end
  end

  assign op              = op_c;
  assign acc             = acc_q;
  assign jmp_off         = (op_c == OP_JRO) ? src_val : imm;
  // Reset must silence clk_en at once, not at the next edge.
  assign clk_en          = clk_en_c & reset_n;
  assign ports.in_ready  = in_ready_c;
  assign ports.out_valid = out_valid_c;
  assign ports.out_data  = out_data_q;

endmodule

// File: tb/tb_node_exec.sv
// Directed self-checking bench for node_exec; one task per scenario.
module tb_node_exec;

  localparam logic [3:0] OP_NOP = 4'd0, OP_MOV = 4'd1, OP_SWP = 4'd2, OP_SAV = 4'd3,
                         OP_ADD = 4'd4, OP_SUB = 4'd5, OP_NEG = 4'd6, OP_JMP = 4'd7,
                         OP_JRO = 4'd12;
  localparam logic [2:0] S_IMM = 3'd0, S_ACC = 3'd1, S_NIL = 3'd2, S_UP = 3'd3,
                         S_DOWN = 3'd4, S_LEFT = 3'd5, S_RIGHT = 3'd6;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [20:0]        opcode;
  logic [3:0]         op;
  logic signed [10:0] acc;
  logic signed [10:0] jmp_off;
  logic               clk_en;
  int checks = 0;
  int errors = 0;

  node_exec_if bus ();

  node_exec dut (
    .clk     (clk),
    .reset_n (reset_n),
    .opcode  (opcode),
    .ports   (bus),
    .op      (op),
    .acc     (acc),
    .jmp_off (jmp_off),
    .clk_en  (clk_en)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] mk(input logic [3:0] o, input logic [2:0] s,
                                     input logic [2:0] d, input logic signed [10:0] i);
    return {o, s, d, i};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    opcode = mk(OP_NOP, S_NIL, S_NIL, 11'sd0);
    bus.in_data = '0; bus.in_valid = '0; bus.out_ready = '0;
    tick(); tick();
    checks++; if (acc !== 11'sd0) begin errors++; $display("FAIL rst_acc got %0d exp 0", acc); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL rst_clk_en got %b exp 0", clk_en); end
    checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL rst_out_valid got %b exp 0000", bus.out_valid); end
    checks++; if (bus.out_data !== 11'd0) begin errors++; $display("FAIL rst_out_data got %0d exp 0", bus.out_data); end
    reset_n = 1'b1;
  endtask

  task automatic test_mov_add;
    opcode = mk(OP_MOV, S_IMM, S_ACC, 11'sd5); #1;
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL mov_clk_en got %b exp 1", clk_en); end
    tick();
    checks++; if (acc !== 11'sd5) begin errors++; $display("FAIL mov_acc got %0d exp 5", acc); end
    opcode = mk(OP_ADD, S_IMM, S_NIL, 11'sd7); #1;
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL add_clk_en got %b exp 1", clk_en); end
    checks++; if (op !== OP_ADD) begin errors++; $display("FAIL op_pass got %0d exp 4", op); end
    tick();
    checks++; if (acc !== 11'sd12) begin errors++; $display("FAIL add_acc got %0d exp 12", acc); end
  endtask

  task automatic test_port_read;
    opcode = mk(OP_MOV, S_LEFT, S_ACC, 11'sd0);
    bus.in_valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL rd_stall_ready got %b exp 0100", bus.in_ready); end
      checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL rd_stall_clk_en got %b exp 0", clk_en); end
      tick();
      checks++; if (acc !== 11'sd12) begin errors++; $display("FAIL rd_stall_acc got %0d exp 12", acc); end
    end
    bus.in_data = {11'd0, 11'd42, 11'd0, 11'd0};
    bus.in_valid = 4'b0100; #1;
    checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL rd_ready got %b exp 0100", bus.in_ready); end
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL rd_clk_en got %b exp 1", clk_en); end
    tick();
    checks++; if (acc !== 11'sd42) begin errors++; $display("FAIL rd_acc got %0d exp 42", acc); end
    bus.in_valid = '0;
    opcode = mk(OP_NOP, S_NIL, S_NIL, 11'sd0);
  endtask

  task automatic test_port_write;
    opcode = mk(OP_MOV, S_IMM, S_ACC, 11'sd9); tick();
    opcode = mk(OP_MOV, S_ACC, S_RIGHT, 11'sd0);
    bus.out_ready = 4'b0000; #1;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL wr_latch_clk_en got %b exp 0", clk_en); end
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.out_ready = (i == 1) ? 4'b0001 : 4'b0000;  // wrong-port ready must not complete
      #1;
      checks++; if (bus.out_valid !== 4'b1000) begin errors++; $display("FAIL wr_valid got %b exp 1000", bus.out_valid); end
      checks++; if (bus.out_data !== 11'd9) begin errors++; $display("FAIL wr_data got %0d exp 9", bus.out_data); end
      checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL wr_hold_clk_en got %b exp 0", clk_en); end
      tick();
    end
    bus.out_ready = 4'b1000; #1;
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL wr_done_clk_en got %b exp 1", clk_en); end
    tick();
    checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL wr_after_valid got %b exp 0000", bus.out_valid); end
    bus.out_ready = '0;
    opcode = mk(OP_NOP, S_NIL, S_NIL, 11'sd0);
  endtask

  task automatic test_port_to_port;
    opcode = mk(OP_MOV, S_UP, S_DOWN, 11'sd0);
    bus.in_data = {33'd0, 11'd77};
    bus.in_valid = 4'b0001; #1;
    checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL p2p_ready got %b exp 0001", bus.in_ready); end
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL p2p_rd_clk_en got %b exp 0", clk_en); end
    tick();
    bus.in_valid = 4'b0000;
    bus.out_ready = 4'b0010; #1;
    checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL p2p_wr_ready got %b exp 0000", bus.in_ready); end
    checks++; if (bus.out_valid !== 4'b0010) begin errors++; $display("FAIL p2p_valid got %b exp 0010", bus.out_valid); end
    checks++; if (bus.out_data !== 11'd77) begin errors++; $display("FAIL p2p_data got %0d exp 77", bus.out_data); end
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL p2p_clk_en got %b exp 1", clk_en); end
    tick();
    bus.out_ready = '0;
    opcode = mk(OP_NOP, S_NIL, S_NIL, 11'sd0);
  endtask

  task automatic test_arith;
`ifdef TIS_SAT_EN
    opcode = mk(OP_MOV, S_IMM, S_ACC, 11'sd990); tick();
    opcode = mk(OP_ADD, S_IMM, S_NIL, 11'sd20); tick();
    checks++; if (acc !== 11'sd999) begin errors++; $display("FAIL sat_add got %0d exp 999", acc); end
    opcode = mk(OP_MOV, S_IMM, S_ACC, -11'sd1020); tick();
    checks++; if (acc !== -11'sd999) begin errors++; $display("FAIL sat_imm got %0d exp -999", acc); end
`else
    opcode = mk(OP_MOV, S_IMM, S_ACC, 11'sd1020); tick();
    opcode = mk(OP_ADD, S_IMM, S_NIL, 11'sd10); tick();
    checks++; if (acc !== -11'sd1018) begin errors++; $display("FAIL wrap_add got %0d exp -1018", acc); end
    opcode = mk(OP_SUB, S_IMM, S_NIL, 11'sd100); tick();
    checks++; if (acc !== 11'sd930) begin errors++; $display("FAIL wrap_sub got %0d exp 930", acc); end
`endif
    opcode = mk(OP_MOV, S_IMM, S_ACC, 11'sd5); tick();
    opcode = mk(OP_NEG, S_NIL, S_NIL, 11'sd0); tick();
    checks++; if (acc !== -11'sd5) begin errors++; $display("FAIL neg got %0d exp -5", acc); end
  endtask

  task automatic test_swp_sav;
    opcode = mk(OP_MOV, S_IMM, S_ACC, 11'sd3); tick();
    opcode = mk(OP_SAV, S_NIL, S_NIL, 11'sd0); tick();
    checks++; if (acc !== 11'sd3) begin errors++; $display("FAIL sav_acc got %0d exp 3", acc); end
    opcode = mk(OP_SWP, S_NIL, S_NIL, 11'sd0); tick();
    checks++; if (acc !== 11'sd3) begin errors++; $display("FAIL swp1_acc got %0d exp 3", acc); end
    opcode = mk(OP_MOV, S_IMM, S_ACC, -11'sd4); tick();
    opcode = mk(OP_SWP, S_NIL, S_NIL, 11'sd0); tick();
    checks++; if (acc !== 11'sd3) begin errors++; $display("FAIL swp2_acc got %0d exp 3", acc); end
    tick();  // second SWP brings BAK back
    checks++; if (acc !== -11'sd4) begin errors++; $display("FAIL swp_bak got %0d exp -4", acc); end
  endtask

  task automatic test_jumps;
    opcode = mk(OP_JRO, S_UP, S_NIL, 11'sd0);
    bus.in_data = {33'd0, 11'h7FE};
    bus.in_valid = 4'b0001; #1;
    checks++; if (jmp_off !== -11'sd2) begin errors++; $display("FAIL jro_off got %0d exp -2", jmp_off); end
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL jro_clk_en got %b exp 1", clk_en); end
    checks++; if (op !== OP_JRO) begin errors++; $display("FAIL jro_op got %0d exp 12", op); end
    tick();
    bus.in_valid = 4'b0000; #1;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL jro_stall got %b exp 0", clk_en); end
    opcode = mk(OP_JMP, S_NIL, S_NIL, -11'sd6); #1;
    checks++; if (jmp_off !== -11'sd6) begin errors++; $display("FAIL jmp_off got %0d exp -6", jmp_off); end
    tick();
    opcode = mk(4'd13, S_IMM, S_ACC, 11'sd100); #1;
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL op13_clk_en got %b exp 1", clk_en); end
    tick();
    checks++; if (acc !== -11'sd4) begin errors++; $display("FAIL op13_acc got %0d exp -4", acc); end
  endtask

  task automatic test_reset_mid_wr;
    opcode = mk(OP_MOV, S_IMM, S_LEFT, 11'sd55);
    bus.out_ready = 4'b0000; tick();
    checks++; if (bus.out_valid !== 4'b0100) begin errors++; $display("FAIL mid_valid got %b exp 0100", bus.out_valid); end
    reset_n = 1'b0; #1;
    checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL mid_rst_valid got %b exp 0000", bus.out_valid); end
    checks++; if (bus.out_data !== 11'd0) begin errors++; $display("FAIL mid_rst_data got %0d exp 0", bus.out_data); end
    checks++; if (acc !== 11'sd0) begin errors++; $display("FAIL mid_rst_acc got %0d exp 0", acc); end
    bus.out_ready = 4'b0100; #1;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL mid_rst_clk_en got %b exp 0", clk_en); end
    tick();
    opcode = mk(OP_NOP, S_NIL, S_NIL, 11'sd0);
    reset_n = 1'b1; #1;
    checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL post_rst_valid got %b exp 0000", bus.out_valid); end
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL post_rst_clk_en got %b exp 1", clk_en); end
    tick();
    bus.out_ready = '0;
  endtask

  initial begin
    test_reset();
    test_mov_add();
    test_port_read();
    test_port_write();
    test_port_to_port();
    test_arith();
    test_swp_sav();
    test_jumps();
    test_reset_mid_wr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
